assert_event_collector: RTL and testbench
=========================================

ASSERT_EVENT_COLLECTOR -- requirements
Module: assert_event_collector

Interface
REQ-001 Parameter N_SRC, default 8, number of checker fail sources (2..32).
REQ-002 Parameter DEPTH, default 8, event FIFO depth, power of two >= 2.
REQ-003 Parameter TS_W, default 16, timestamp width.
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 fail_i  input  N_SRC  per-source one-cycle fail pulse from a checker instance.
REQ-008 evt_valid  output  1  event record available.
REQ-009 evt_ready  input  1  consumer accepts record.
REQ-010 evt_id  output  $clog2(N_SRC)  source index of head record.
REQ-011 evt_ts  output  TS_W  timestamp of head record.
REQ-012 fail_count  output  CNT_W  total fail pulses captured, saturating.
REQ-013 drop_count  output  CNT_W  fail pulses lost, saturating.
REQ-014 overflow  output  1  sticky: set on any drop.

Function
REQ-015 Free-running counter ts SHALL increment by 1 every cycle and wrap from 2^TS_W-1 to 0.
REQ-016 fail_i[k] high in cycle c with pending[k] clear SHALL set pending[k] and store pts[k]=ts(c) at end of cycle c; fail_count +1.
REQ-017 fail_i[k] high while pending[k] set and not granted that cycle SHALL be dropped: drop_count +1, overflow set, pts[k] unchanged; fail_count +1.
REQ-018 Multiple fail_i bits in one cycle SHALL each be handled independently per REQ-016/017; counters SHALL add the popcount of captured/dropped bits in one cycle.
REQ-019 Arbiter: each cycle, if FIFO count < DEPTH and any pending bit set, SHALL grant the first pending index at or above rr_ptr (cyclic), push {k, pts[k]}, clear pending[k], set rr_ptr=(k+1) mod N_SRC.
REQ-020 Push when FIFO full SHALL not occur, even with same-cycle pop; pending bits wait.
REQ-021 Granted source k receiving a new fail_i[k] in the grant cycle SHALL re-set pending[k] with the new ts, not counted as drop.
REQ-022 At most one push and one pop per cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-023 evt_valid = FIFO non-empty; evt_id/evt_ts SHALL show head record and stay stable while evt_valid && !evt_ready.
REQ-024 Pop SHALL occur when evt_valid && evt_ready; evt_ready while empty SHALL have no effect.
REQ-025 Latency: pulse in cycle 0, no contention, empty FIFO -> evt_valid high in cycle 2.
REQ-026 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; order of records SHALL equal grant order.

Reset
REQ-028 rst_n low SHALL asynchronously clear ts, pending, pts, rr_ptr, FIFO pointers/count, fail_count, drop_count, overflow.
REQ-029 During and after reset: evt_valid=0, evt_id=0, evt_ts=0, counters 0, overflow 0.
REQ-030 Reset mid-operation SHALL discard all queued and pending events; fail_i ignored while rst_n low.
REQ-031 Reset release SHALL be synchronous-safe: first capture on first posedge with rst_n high.

Structure
REQ-032 Package assert_evt_pkg SHALL hold the record struct evt_rec_t {id, ts} and default parameter constants.
REQ-033 FIFO SHALL be one sub-module assert_evt_fifo (parameterized width/depth, count output); arbiter and capture logic inline.

Verification
REQ-034 Single pulse fail_i=8'h04 at ts=10, evt_ready=1 -> evt_valid in cycle+2, evt_id=2, evt_ts=10, fail_count=1.
REQ-035 fail_i=8'hFF one cycle, evt_ready=1, rr_ptr=0 -> ids 0..7 in order, all evt_ts equal, fail_count=8, drop_count=0.
REQ-036 evt_ready=0, 10 pulses on distinct cycles across sources 0..7,0,1 -> FIFO holds 8, sources 0,1 stay pending; second pulse on 0 before drain -> drop_count=1, overflow=1.
REQ-037 Back-pressure: evt_ready toggled 1/0 each cycle -> head stable while not ready, no loss, order preserved.
REQ-038 Force counters near max (CNT_W=4, 20 pulses) -> fail_count holds 15; ts wrap with TS_W=4 -> evt_ts 15 then 0.
REQ-039 rst_n low mid-stream with 5 queued -> evt_valid=0 immediately, all counters 0, no stale record after release.

Source files
------------

// File: rtl/assert_evt_pkg.sv
// assert_evt_pkg: shared record type, default sizing and a popcount helper for the event collector
package assert_evt_pkg;
  localparam int N_SRC_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int TS_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  localparam int ID_W_DEF = $clog2(N_SRC_DEF);
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] ts;
  } evt_rec_t;
  function automatic logic [5:0] popcnt(input logic [31:0] v);
    popcnt = '0;
    for (int i = 0; i < 32; i++) popcnt = popcnt + 6'(v[i]);
  endfunction
endpackage

// File: rtl/assert_evt_fifo.sv
// assert_evt_fifo: power-of-two ring buffer with occupancy count; ignores push when full and pop when empty
module assert_evt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push && count != FULL;
  assign do_pop = pop && count != '0;
  assign rdata = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/assert_event_collector.sv
// assert_event_collector: captures checker fail pulses, arbitrates round-robin into a timestamped event FIFO
module assert_event_collector
  import assert_evt_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           fail_i,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(N_SRC)-1:0]   evt_id,
  output logic [TS_W-1:0]            evt_ts,
  output logic [CNT_W-1:0]           fail_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       overflow
);
  localparam int IDW = $clog2(N_SRC);
  localparam int AW = $clog2(DEPTH);
  localparam int W = IDW + TS_W;
  localparam int SW = CNT_W + 6;
  localparam logic [IDW:0] NS = (IDW+1)'(N_SRC);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [TS_W-1:0] ts;
  logic [N_SRC-1:0] pending, rot, grant_v, drop_v;
  logic [TS_W-1:0] pts [N_SRC];
  logic [IDW-1:0] rr_ptr, off, gidx;
  logic [IDW:0] gsum, rr_nx;
  logic gnt;
  logic [AW:0] count;
  logic [W-1:0] head;
  logic [SW-1:0] fsum, dsum;
  // Rotating pending by rr_ptr turns the cyclic search into a lowest-set-bit search
  always_comb begin
    rot = N_SRC'({pending, pending} >> rr_ptr);
    off = '0;
    gnt = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (rot[i]) begin
        off = IDW'(i);
        gnt = 1'b1;
      end
    gnt = gnt && count != FULL;
    gsum = {1'b0, rr_ptr} + {1'b0, off};
    gidx = gsum >= NS ? IDW'(gsum - NS) : gsum[IDW-1:0];
    rr_nx = {1'b0, gidx} + (IDW+1)'(1);
    grant_v = {{(N_SRC-1){1'b0}}, gnt} << gidx;
    drop_v = fail_i & pending & ~grant_v;
    fsum = SW'(fail_count) + SW'(popcnt(32'(fail_i)));
    dsum = SW'(drop_count) + SW'(popcnt(32'(drop_v)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts <= '0;
      pending <= '0;
      rr_ptr <= '0;
      fail_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < N_SRC; k++) pts[k] <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      pending <= (pending & ~grant_v) | fail_i;
      for (int k = 0; k < N_SRC; k++)
        if (fail_i[k] && !drop_v[k]) pts[k] <= ts;
      if (gnt) rr_ptr <= rr_nx == NS ? '0 : rr_nx[IDW-1:0];
      fail_count <= fsum > SW'(CMAX) ? CMAX : fsum[CNT_W-1:0];
      drop_count <= dsum > SW'(CMAX) ? CMAX : dsum[CNT_W-1:0];
      overflow <= overflow | (|drop_v);
    end
  assert_evt_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(gnt),
    .wdata({gidx, pts[gidx]}),
    .pop(evt_valid && evt_ready),
    .rdata(head),
    .count(count)
  );
  assign evt_valid = count != '0;
  assign evt_id = evt_valid ? head[W-1:TS_W] : '0;
  assign evt_ts = evt_valid ? head[TS_W-1:0] : '0;
endmodule

// File: tb/tb_assert_event_collector.sv
// tb_assert_event_collector: table, directed and random checks against a queue-based reference model
module tb_assert_event_collector;
  localparam int N = 8;
  localparam int DEPTH = 8;
  localparam int CMAX = 65535;
  localparam int TSMOD = 65536;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] fail_i = '0;
  logic evt_ready = 1'b0;
  logic evt_valid, overflow;
  logic [2:0] evt_id;
  logic [15:0] evt_ts, fail_count, drop_count;
  logic [7:0] fail2 = '0, f2 = '0;
  logic ready2 = 1'b0, r2 = 1'b0;
  logic v2, ov2;
  logic [2:0] id2;
  logic [3:0] ts2, fc2, dc2;
  int checks = 0, failures = 0;
  typedef struct { int id; int ts; } rec_t;
  typedef struct { logic [7:0] f; logic r; logic v; int id; int ts; int fc; int dc; } vec_t;
  rec_t mq[$];
  vec_t tbl[10];
  bit m_pend[N];
  int m_pts[N];
  int m_rr, m_ts, m_fail, m_drop, n2;
  bit m_ovf;

  always #5 clk = ~clk;

  assert_event_collector dut (
    .clk(clk), .rst_n(rst_n), .fail_i(fail_i), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_ts(evt_ts), .fail_count(fail_count), .drop_count(drop_count), .overflow(overflow)
  );
  assert_event_collector #(.N_SRC(8), .DEPTH(8), .TS_W(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .fail_i(fail2), .evt_valid(v2), .evt_ready(ready2),
    .evt_id(id2), .evt_ts(ts2), .fail_count(fc2), .drop_count(dc2), .overflow(ov2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0;
      m_pts[k] = 0;
    end
    m_rr = 0; m_ts = 0; m_fail = 0; m_drop = 0; m_ovf = 0; n2 = 0;
  endtask

  task automatic model_step(input logic [7:0] f, input logic r);
    int sz, g;
    sz = mq.size();
    g = -1;
    if (sz < DEPTH)
      for (int i = 0; i < N; i++)
        if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
    if (r && sz > 0) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{g, m_pts[g]});
      m_pend[g] = 0;
      m_rr = (g + 1) % N;
    end
    for (int k = 0; k < N; k++)
      if (f[k]) begin
        if (m_fail < CMAX) m_fail++;
        if (m_pend[k]) begin
          if (m_drop < CMAX) m_drop++;
          m_ovf = 1;
        end else begin
          m_pend[k] = 1;
          m_pts[k] = m_ts;
        end
      end
    m_ts = (m_ts + 1) % TSMOD;
  endtask

  task automatic tick(input logic [7:0] f, input logic r);
    logic hold;
    logic [2:0] hid;
    logic [15:0] hts;
    fail_i = f; evt_ready = r; fail2 = f2; ready2 = r2;
    hold = evt_valid && !r;
    hid = evt_id;
    hts = evt_ts;
    model_step(f, r);
    @(posedge clk);
    #1;
    n2++;
    if (hold) begin
      chk("hold_id", evt_id, hid);
      chk("hold_ts", evt_ts, hts);
    end
    chk("valid", evt_valid, mq.size() > 0 ? 1 : 0);
    chk("id", evt_id, mq.size() > 0 ? mq[0].id : 0);
    chk("ts", evt_ts, mq.size() > 0 ? mq[0].ts : 0);
    chk("fail_count", fail_count, m_fail);
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_fc", fail_count, 0);
    chk("rst_dc", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_v2", v2, 0);
    chk("rst_fc2", fc2, 0);
    fail_i = '1; fail2 = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", evt_valid, 0);
    chk("rst_hold_fc", fail_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fail_i = '0; fail2 = '0; f2 = '0; r2 = 1'b0;
    model_reset();
  endtask

  initial begin
    #2;
    do_reset();
    // All sources fire together: drained in index order, one per cycle
    for (int i = 0; i < 10; i++)
      tbl[i] = '{f: (i == 0) ? 8'hFF : 8'h00, r: 1'b1, v: (i >= 1 && i <= 8), id: i - 1, ts: 0, fc: 8, dc: 0};
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].f, tbl[i].r);
      chk("tbl_valid", evt_valid, tbl[i].v);
      if (tbl[i].v) begin
        chk("tbl_id", evt_id, tbl[i].id);
        chk("tbl_ts", evt_ts, tbl[i].ts);
      end
      chk("tbl_fc", fail_count, tbl[i].fc);
      chk("tbl_dc", drop_count, tbl[i].dc);
    end
    // Single pulse latency at ts=10
    do_reset();
    repeat (10) tick(8'h00, 1'b1);
    tick(8'h04, 1'b1);
    chk("lat_c1_valid", evt_valid, 0);
    tick(8'h00, 1'b1);
    chk("lat_c2_valid", evt_valid, 1);
    chk("lat_id", evt_id, 2);
    chk("lat_ts", evt_ts, 10);
    chk("lat_fc", fail_count, 1);
    tick(8'h00, 1'b1);
    // Fill the FIFO without draining, then overrun source 0
    do_reset();
    for (int i = 0; i < 10; i++) tick(8'(1 << (i % 8)), 1'b0);
    tick(8'h01, 1'b0);
    chk("full_dc", drop_count, 1);
    chk("full_ovf", overflow, 1);
    chk("full_fc", fail_count, 11);
    chk("full_head", evt_id, 0);
    repeat (12) tick(8'h00, 1'b1);
    chk("full_drained", evt_valid, 0);
    // Random traffic, first with toggling ready, then random ready
    for (int i = 0; i < 400; i++)
      tick(8'($urandom & $urandom), (i < 200) ? 1'(i % 2) : 1'($urandom % 2));
    // Narrow instance: timestamp wrap and counter saturation
    do_reset();
    r2 = 1'b1;
    repeat (15) tick(8'h00, 1'b1);
    f2 = 8'h01;
    tick(8'h00, 1'b1);
    f2 = 8'h02;
    tick(8'h00, 1'b1);
    chk("wrap_v", v2, 1);
    chk("wrap_id0", id2, 0);
    chk("wrap_ts15", ts2, 15);
    f2 = 8'h00;
    tick(8'h00, 1'b1);
    chk("wrap_id1", id2, 1);
    chk("wrap_ts0", ts2, 0);
    chk("wrap_fc", fc2, 2);
    for (int i = 0; i < 20; i++) begin
      f2 = 8'(1 << (i % 8));
      tick(8'h00, 1'b1);
      chk("sat_fc", fc2, (3 + i > 15) ? 15 : 3 + i);
    end
    f2 = 8'h00;
    tick(8'h00, 1'b1);
    chk("sat_dc", dc2, 0);
    chk("sat_ovf", ov2, 0);
    // Reset with five records queued
    do_reset();
    for (int i = 0; i < 5; i++) tick(8'(1 << i), 1'b0);
    tick(8'h00, 1'b0);
    chk("pre_rst_valid", evt_valid, 1);
    do_reset();
    repeat (5) tick(8'h00, 1'b1);
    chk("post_rst_valid", evt_valid, 0);
    chk("post_rst_fc", fail_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
